// File: rtl/ars_field_pkg.sv
// ars_field_pkg: GF(2^233) constants, FSM encoding and field helpers
// shared by the projective-to-affine converter and its sub-blocks.
package ars_field_pkg;

  localparam int M   = 233;
  localparam int TAP = 74;

  localparam logic [M-1:0] ZERO_M = '0;
  localparam logic [M-1:0] ONE_M  = {{(M-1){1'b0}}, 1'b1};
  // Low part of f(t) = t^233 + t^74 + 1
  localparam logic [M-1:0] RED_M  = ONE_M | (ONE_M << TAP);

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_INV  = 3'd1;
  localparam state_t S_MX   = 3'd2;
  localparam state_t S_GAP  = 3'd3;
  localparam state_t S_MY   = 3'd4;
  localparam state_t S_FIN  = 3'd5;

  function automatic logic [M-1:0] gf_mulx(
    input logic [M-1:0] a
  );
    logic [M-1:0] s;
    s = {a[M-2:0], 1'b0};
    if (a[M-1]) s = s ^ RED_M;
    return s;
  endfunction

  // a / t: an odd a first absorbs f so the shift is exact
  function automatic logic [M-1:0] gf_divx(
    input logic [M-1:0] a
  );
    logic [M-1:0] s;
    s = {1'b0, a[M-1:1]};
    if (a[0]) begin
      s = s ^ (ONE_M << (M - 1));
      s = s ^ (ONE_M << (TAP - 1));
    end
    return s;
  endfunction

  function automatic logic [M-1:0] gf_red(
    input logic [2*M-2:0] c
  );
    logic [2*M-2:0] r;
    r = c;
    for (int i = 2*M-2; i >= M; i--) begin
      if (r[i]) begin
        r[i]             = 1'b0;
        r[i - M + TAP]   = ~r[i - M + TAP];
        r[i - M]         = ~r[i - M];
      end
    end
    return r[M-1:0];
  endfunction

endpackage

// File: rtl/ARS_inverse.sv
// ARS_inverse: binary extended-Euclid inversion in GF(2^233),
// one reduction step per cycle; cleared whenever i_en is low.
module ARS_inverse
  import ars_field_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [M-1:0] i_a,
  output logic [M-1:0] o_aout,
  output logic         o_rdy
);

  localparam logic [M:0] F_POLY = {1'b1, RED_M};
  localparam logic [M:0] U_ONE  = {1'b0, ONE_M};

  logic [M:0]   r_u;
  logic [M:0]   r_v;
  logic [M-1:0] r_g1;
  logic [M-1:0] r_g2;
  logic [M-1:0] r_res;
  logic         r_run;
  logic         r_rdy;
  logic         w_u_gt;

  function automatic logic [8:0] deg(input logic [M:0] p);
    logic [8:0] d;
    d = '0;
    for (int i = 0; i <= M; i++) begin
      if (p[i]) d = 9'(i);
    end
    return d;
  endfunction

  assign w_u_gt = deg(r_u) > deg(r_v);
  assign o_aout = r_res;
  assign o_rdy  = r_rdy;

  // Invariants: g1*a == u and g2*a == v (mod f)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_u   <= '0;
      r_v   <= '0;
      r_g1  <= '0;
      r_g2  <= '0;
      r_res <= '0;
      r_run <= 1'b0;
      r_rdy <= 1'b0;
    end else if (!i_en) begin
      r_run <= 1'b0;
      r_rdy <= 1'b0;
    end else if (!r_run) begin
      r_u   <= {1'b0, i_a};
      r_v   <= F_POLY;
      r_g1  <= ONE_M;
      r_g2  <= ZERO_M;
      r_run <= 1'b1;
    end else if (!r_rdy) begin
      if (r_u == U_ONE) begin
        r_res <= r_g1;
        r_rdy <= 1'b1;
      end else if (r_v == U_ONE) begin
        r_res <= r_g2;
        r_rdy <= 1'b1;
      end else if (r_u == '0) begin
        r_res <= ZERO_M;
        r_rdy <= 1'b1;
      end else if (!r_u[0]) begin
        r_u  <= r_u >> 1;
        r_g1 <= gf_divx(r_g1);
      end else if (!r_v[0]) begin
        r_v  <= r_v >> 1;
        r_g2 <= gf_divx(r_g2);
      end else if (w_u_gt) begin
        r_u  <= r_u ^ r_v;
        r_g1 <= r_g1 ^ r_g2;
      end else begin
        r_v  <= r_v ^ r_u;
        r_g2 <= r_g2 ^ r_g1;
      end
    end
  end

endmodule

// File: rtl/ARS_mult_ip.sv
// ARS_mult_ip: bit-serial MSB-first GF(2^233) multiplier.
// Runs while i_en is high; rdy holds until i_en drops, which clears it.
module ARS_mult_ip
  import ars_field_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [M-1:0] i_a,
  input  logic [M-1:0] i_b,
  output logic [M-1:0] o_p,
  output logic         o_rdy
);

  logic [7:0]   r_cnt;
  logic [M-1:0] r_acc;
  logic         r_rdy;
  logic [7:0]   w_idx;

  assign w_idx = 8'(M - 1) - r_cnt;
  assign o_p   = r_acc;
  assign o_rdy = r_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_rdy <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_rdy <= 1'b0;
    end else if (!r_rdy) begin
      r_acc <= gf_mulx(r_acc) ^ (i_b[w_idx] ? i_a : ZERO_M);
      r_cnt <= r_cnt + 8'd1;
      r_rdy <= (r_cnt == 8'(M - 1));
    end
  end

endmodule

// File: rtl/ARS_squar.sv
// ARS_squar: combinational squaring in GF(2^233).
// Interleave zeros, then fold the upper half back through f(t).
module ARS_squar
  import ars_field_pkg::*;
(
  input  logic [M-1:0] i_a,
  output logic [M-1:0] o_c
);

  logic [2*M-2:0] w_sp;

  always_comb begin
    w_sp = '0;
    for (int i = 0; i < M; i++) begin
      w_sp[2*i] = i_a[i];
    end
    o_c = gf_red(w_sp);
  end

endmodule

// File: rtl/ars_mul_seq.sv
// ars_mul_seq: owns the ARS_mult_ip en/rdy handshake.
// A go latches operands and raises en; en drops on the edge after rdy.
module ars_mul_seq
  import ars_field_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_go,
  input  logic [M-1:0] i_a,
  input  logic [M-1:0] i_b,
  output logic [M-1:0] o_p,
  output logic         o_rdy,
  output logic         o_en
);

  logic         r_en;
  logic [M-1:0] r_a;
  logic [M-1:0] r_b;
  logic         w_rdy;
  logic [M-1:0] w_p;

  ARS_mult_ip u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (r_en),
    .i_a   (r_a),
    .i_b   (r_b),
    .o_p   (w_p),
    .o_rdy (w_rdy)
  );

  assign o_p   = w_p;
  assign o_rdy = r_en & w_rdy;
  assign o_en  = r_en;

  // go is ignored while en is high, so en always sees a low cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en <= 1'b0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (r_en) begin
      if (w_rdy) r_en <= 1'b0;
    end else if (i_go) begin
      r_en <= 1'b1;
      r_a  <= i_a;
      r_b  <= i_b;
    end
  end

endmodule

// File: rtl/ars_proj_to_affine.sv
// ars_proj_to_affine: Lopez-Dahab (X,Y,Z) to affine (X/Z, Y/Z^2)
// over GF(2^233); one inverse, then two products on a shared multiplier.
module ars_proj_to_affine
  import ars_field_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] X,
  input  logic [M-1:0] Y,
  input  logic [M-1:0] Z,
  output logic         busy,
  output logic         done,
  output logic         inf,
  output logic [M-1:0] x_out,
  output logic [M-1:0] y_out
);

  state_t       r_state;
  logic [M-1:0] r_xr;
  logic [M-1:0] r_yr;
  logic [M-1:0] r_zr;
  logic [M-1:0] r_zi;
  logic [M-1:0] r_xa;
  logic [M-1:0] r_ya;
  logic [M-1:0] r_xo;
  logic [M-1:0] r_yo;
  logic         r_inv_en;
  logic         r_inf;
  logic         r_done;
  logic         r_busy;

  logic         w_inv_en;
  logic         w_inv_rdy;
  logic [M-1:0] w_inv_aout;
  logic         w_mul_en;
  logic         w_mul_rdy;
  logic [M-1:0] w_mul_p;
  logic [M-1:0] w_sq;
  logic [M-1:0] w_ma;
  logic [M-1:0] w_mb;
  logic         w_gap;
  logic         w_go;
  logic         w_accept;
  logic         w_zero;

  assign w_inv_en = r_inv_en;
  assign w_gap    = (r_state == S_GAP);
  assign w_zero   = (Z == ZERO_M);
  // done cycle is still part of the previous operation
  assign w_accept = (r_state == S_IDLE) && start && !r_done;
  assign w_go     = w_gap || ((r_state == S_INV) && w_inv_rdy);
  assign w_ma     = w_gap ? r_yr : r_xr;
  assign w_mb     = w_gap ? w_sq : w_inv_aout;

  assign busy  = r_busy;
  assign done  = r_done;
  assign inf   = r_inf;
  assign x_out = r_xo;
  assign y_out = r_yo;

  ARS_inverse u_inv (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_inv_en),
    .i_a    (r_zr),
    .o_aout (w_inv_aout),
    .o_rdy  (w_inv_rdy)
  );

  ARS_squar u_sq (
    .i_a (r_zi),
    .o_c (w_sq)
  );

  ars_mul_seq u_mseq (
    .clk   (clk),
    .rst_n (rst_n),
    .i_go  (w_go),
    .i_a   (w_ma),
    .i_b   (w_mb),
    .o_p   (w_mul_p),
    .o_rdy (w_mul_rdy),
    .o_en  (w_mul_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_xr     <= '0;
      r_yr     <= '0;
      r_zr     <= '0;
      r_zi     <= '0;
      r_xa     <= '0;
      r_ya     <= '0;
      r_xo     <= '0;
      r_yo     <= '0;
      r_inv_en <= 1'b0;
      r_inf    <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_busy <= w_accept;
          if (w_accept) begin
            r_xr     <= X;
            r_yr     <= Y;
            r_zr     <= Z;
            r_inf    <= w_zero;
            r_inv_en <= !w_zero;
            r_state  <= w_zero ? S_FIN : S_INV;
          end
        end
        S_INV: begin
          if (w_inv_rdy) begin
            r_zi     <= w_inv_aout;
            r_inv_en <= 1'b0;
            r_state  <= S_MX;
          end
        end
        S_MX: begin
          if (w_mul_rdy) begin
            r_xa    <= w_mul_p;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          r_state <= S_MY;
        end
        S_MY: begin
          if (w_mul_rdy) begin
            r_ya    <= w_mul_p;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_xo    <= r_inf ? ZERO_M : r_xa;
          r_yo    <= r_inf ? ZERO_M : r_ya;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ars_proj_to_affine.sv
// tb_ars_proj_to_affine: directed table plus handshake, reset and
// random corner sequences for the projective-to-affine converter.
`timescale 1ns/1ps
module tb_ars_proj_to_affine;

  localparam int M = 233;
  localparam int LIMIT = 4000;
  typedef logic [M-1:0] fe_t;
  localparam fe_t F_ONE = fe_t'(1);
  localparam fe_t F_LO = F_ONE | (F_ONE << 74);

  typedef struct {
    string nm;
    fe_t   x;
    fe_t   y;
    fe_t   z;
    fe_t   ex;
    fe_t   ey;
    logic  ei;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  fe_t  X = '0;
  fe_t  Y = '0;
  fe_t  Z = '0;
  logic busy;
  logic done;
  logic inf;
  fe_t  x_out;
  fe_t  y_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int n_done = 0;
  int n_inv_rise = 0;
  int inv_rise_c = 0;
  int inv_rdy_c = 0;
  int mrise_prev = 0;
  int mrise_last = 0;
  int mrdy_prev = 0;
  int mrdy_last = 0;
  logic p_inv_en = 1'b0;
  logic p_inv_rdy = 1'b0;
  logic p_mul_en = 1'b0;
  logic p_mul_rdy = 1'b0;

  always #5 clk = ~clk;

  ars_proj_to_affine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .X     (X),
    .Y     (Y),
    .Z     (Z),
    .busy  (busy),
    .done  (done),
    .inf   (inf),
    .x_out (x_out),
    .y_out (y_out)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) n_done++;
    if (dut.w_inv_en && !p_inv_en) begin
      n_inv_rise++;
      inv_rise_c = cyc;
    end
    if (dut.w_inv_rdy && !p_inv_rdy) inv_rdy_c = cyc;
    if (dut.w_mul_en && !p_mul_en) begin
      mrise_prev = mrise_last;
      mrise_last = cyc;
    end
    if (dut.w_mul_rdy && !p_mul_rdy) begin
      mrdy_prev = mrdy_last;
      mrdy_last = cyc;
    end
    p_inv_en  = dut.w_inv_en;
    p_inv_rdy = dut.w_inv_rdy;
    p_mul_en  = dut.w_mul_en;
    p_mul_rdy = dut.w_mul_rdy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic fe_t ref_mul(input fe_t a, input fe_t b);
    fe_t r;
    fe_t s;
    r = '0;
    s = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) r = r ^ s;
      s = s[M-1] ? ((s << 1) ^ F_LO) : (s << 1);
    end
    return r;
  endfunction

  function automatic fe_t rnd_fe();
    fe_t r;
    r = '0;
    for (int i = 0; i < 8; i++) r = (r << 32) | fe_t'($urandom);
    return r;
  endfunction

  task automatic chk(input string nm, input fe_t act, input fe_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input fe_t ix, input fe_t iy, input fe_t iz,
                        output int lat, output bit to);
    int n;
    int t0;
    @(negedge clk);
    X = ix;
    Y = iy;
    Z = iz;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    to = !done;
    lat = cyc - t0;
  endtask

  vec_t tbl[8];
  int   lat;
  bit   to;
  int   exp_lat;
  int   r0;
  int   d0;
  int   n;
  fe_t  rx, ry, rz;

  initial begin
    tbl[0] = '{"z_one",  fe_t'(2), fe_t'(4), fe_t'(1), fe_t'(2), fe_t'(4), 1'b0};
    tbl[1] = '{"z_t",    fe_t'(2), fe_t'(4), fe_t'(2), fe_t'(1), fe_t'(1), 1'b0};
    tbl[2] = '{"z_zero", fe_t'('h1234), fe_t'('hABCD), fe_t'(0),
               fe_t'(0), fe_t'(0), 1'b1};
    tbl[3] = '{"pow_t",  fe_t'(8), fe_t'('h20), fe_t'(2), fe_t'(4), fe_t'(8), 1'b0};
    tbl[4] = '{"xy_zero", fe_t'(0), fe_t'(0), fe_t'(1), fe_t'(0), fe_t'(0), 1'b0};
    tbl[5] = '{"ones",   fe_t'(1), fe_t'(1), fe_t'(1), fe_t'(1), fe_t'(1), 1'b0};
    // t^-1 = t^232 + t^73 and t^-2 = t^231 + t^72 under f(t)
    tbl[6] = '{"t_inv",  fe_t'(1), fe_t'(1), fe_t'(2),
               (F_ONE << 232) | (F_ONE << 73),
               (F_ONE << 231) | (F_ONE << 72), 1'b0};
    tbl[7] = '{"z_t2",   fe_t'(4), fe_t'('h10), fe_t'(4), fe_t'(1), fe_t'(1), 1'b0};

    repeat (3) @(negedge clk);
    chk("reset done", fe_t'(done), fe_t'(0));
    chk("reset busy", fe_t'(busy), fe_t'(0));
    chk("reset inf", fe_t'(inf), fe_t'(0));
    chk("reset x_out", x_out, '0);
    chk("reset y_out", y_out, '0);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      r0 = n_inv_rise;
      run_op(tbl[k].x, tbl[k].y, tbl[k].z, lat, to);
      chk({tbl[k].nm, " timeout"}, fe_t'(to), fe_t'(0));
      chk({tbl[k].nm, " x_out"}, x_out, tbl[k].ex);
      chk({tbl[k].nm, " y_out"}, y_out, tbl[k].ey);
      chk({tbl[k].nm, " inf"}, fe_t'(inf), fe_t'(tbl[k].ei));
      chk({tbl[k].nm, " busy@done"}, fe_t'(busy), fe_t'(1));
      if (tbl[k].ei) begin
        chk({tbl[k].nm, " latency"}, fe_t'(lat), fe_t'(2));
        chk({tbl[k].nm, " inv_en rises"}, fe_t'(n_inv_rise - r0), fe_t'(0));
      end else begin
        // start, L_inv, ->MX, L_mul, ->GAP, GAP->MY, L_mul, ->FIN, ->done
        exp_lat = 1 + (inv_rdy_c - inv_rise_c) + 1 + (mrdy_prev - mrise_prev)
                + 1 + 1 + (mrdy_last - mrise_last) + 1 + 1;
        chk({tbl[k].nm, " latency"}, fe_t'(lat), fe_t'(exp_lat));
      end
      @(negedge clk);
      chk({tbl[k].nm, " done pulse"}, fe_t'(done), fe_t'(0));
      chk({tbl[k].nm, " busy after"}, fe_t'(busy), fe_t'(0));
    end

    // start during the done cycle must be ignored
    run_op(fe_t'('h55), fe_t'('h66), fe_t'(0), lat, to);
    chk("done-start timeout", fe_t'(to), fe_t'(0));
    X = fe_t'('h77);
    Z = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = n_done;
    repeat (6) @(negedge clk);
    chk("done-start extra done", fe_t'(n_done - d0), fe_t'(0));
    chk("done-start busy", fe_t'(busy), fe_t'(0));

    // second start while multiplying is dropped
    @(negedge clk);
    d0 = n_done;
    X = fe_t'(8);
    Y = fe_t'('h20);
    Z = fe_t'(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!dut.w_mul_en && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("mid reach MX", fe_t'(dut.w_mul_en), fe_t'(1));
    X = fe_t'(1);
    Y = fe_t'(1);
    Z = fe_t'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("mid timeout", fe_t'(done), fe_t'(1));
    chk("mid x_out", x_out, fe_t'(4));
    chk("mid y_out", y_out, fe_t'(8));
    repeat (20) @(negedge clk);
    chk("mid done count", fe_t'(n_done - d0), fe_t'(1));

    // asynchronous reset while inverting
    X = fe_t'(2);
    Y = fe_t'(4);
    Z = fe_t'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!dut.w_inv_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst reach INV", fe_t'(dut.w_inv_en), fe_t'(1));
    repeat (2) @(negedge clk);
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    chk("rst x_out", x_out, '0);
    chk("rst y_out", y_out, '0);
    chk("rst busy", fe_t'(busy), fe_t'(0));
    chk("rst inv_en", fe_t'(dut.w_inv_en), fe_t'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst spurious done", fe_t'(n_done - d0), fe_t'(0));
    run_op(fe_t'(2), fe_t'(4), fe_t'(2), lat, to);
    chk("post-rst timeout", fe_t'(to), fe_t'(0));
    chk("post-rst x_out", x_out, fe_t'(1));
    chk("post-rst y_out", y_out, fe_t'(1));

    for (int k = 0; k < 30; k++) begin
      rx = rnd_fe();
      ry = rnd_fe();
      rz = rnd_fe();
      if (rz == '0) rz = fe_t'(1);
      run_op(rx, ry, rz, lat, to);
      chk("rnd timeout", fe_t'(to), fe_t'(0));
      chk("rnd x*Z", ref_mul(x_out, rz), rx);
      chk("rnd y*Z^2", ref_mul(y_out, ref_mul(rz, rz)), ry);
      chk("rnd inf", fe_t'(inf), fe_t'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
